dmem_ctrl: RTL and testbench

Parametrised data memory for the CPU load/store path, the successor to the fixed single-cycle word memory. Byte-addressed, with byte/half/word accesses, sign/zero extension, a valid/ready request and response handshake, configurable depth, base address and read latency, and error reporting for misaligned or out-of-range accesses. Sits between the core's memory stage and the data storage. Exactly one transaction is outstanding at a time.

---
 rtl/dmem_pkg.sv | 61 ++++++
 rtl/dmem_array.sv | 37 +++
 rtl/dmem_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and helpers for the dmem_ctrl data memory
//
// Purpose: access-size and FSM state enums, pattern-region size, and the
// helper functions for load lane extraction/extension and store strobes.
// Ports: none (package).
// Optional feature macro used by the design: DMEM_PATTERN_EN.

package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned PATTERN_WORDS = 32;

  // Select the addressed lane of a memory word and extend it to 32 bits.
  // An illegal size yields zero; callers only use it for legal accesses.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic [31:0] res;
    byte_sh = word >> {lane, 3'b000};
    half_sh = word >> {lane[1], 4'b0000};
    res     = 32'h0;
    if (size == SZ_BYTE) begin
      res = {{24{~uns & byte_sh[7]}}, byte_sh[7:0]};
    end else if (size == SZ_HALF) begin
      res = {{16{~uns & half_sh[15]}}, half_sh[15:0]};
    end else if (size == SZ_WORD) begin
      res = word;
    end
    return res;
  endfunction

  // Byte write enables for a store; paired with lane-replicated write data.
  function automatic logic [3:0] strobe_gen(input logic [1:0] lane,
                                            input logic [1:0] size);
    logic [3:0] strb;
    strb = 4'b0000;
    if (size == SZ_BYTE) begin
      strb = 4'b0001 << lane;
    end else if (size == SZ_HALF) begin
      strb = 4'b0011 << {lane[1], 1'b0};
    end else if (size == SZ_WORD) begin
      strb = 4'b1111;
    end
    return strb;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - DEPTH_WORDS x 32 storage with byte write enables
//
// Purpose: plain word storage, one synchronous byte-masked write port and
// one asynchronous read port. Contents are never reset.
// Ports:
//   clk_i    clock
//   we_i     per-byte write enable (bit n writes wdata_i[8n+7:8n])
//   waddr_i  write word index
//   wdata_i  write data (already lane-aligned)
//   raddr_i  read word index
//   rdata_o  read data, combinational from raddr_i

module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) begin
        mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-addressed data memory with valid/ready handshake
//
// Purpose: load/store data memory for the CPU memory stage. Byte/half/word
// accesses, sign/zero extension, configurable depth, base address and read
// latency, error response for misaligned, illegal-size or out-of-range
// accesses. One transaction outstanding at a time.
// Optional feature: define DMEM_PATTERN_EN to make word indices 0..31 a
// read-only pattern region returning (1 << idx).
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake
//   req_write                 1 = store, 0 = load
//   req_addr                  byte address
//   req_size                  0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned              zero-extend loads when 1
//   req_wdata                 right-aligned store data
//   resp_valid / resp_ready   response handshake
//   resp_rdata                formatted load data, 0 for stores/errors
//   resp_err                  access error flag

module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned AW          = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RANGE_BYTES = 32'(DEPTH_WORDS * 4);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    lane_q, lane_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          pat_q, pat_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Request decode. The unsigned subtraction wraps addresses below the base
  // to large offsets, so a single compare covers both range bounds.
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] req_idx;
  logic          req_err;
  logic          req_pat;
  logic          accept;

  assign offset   = req_addr - BASE_ADDR;
  assign in_range = (offset < RANGE_BYTES);
  assign req_idx  = offset[AW+1:2];
  assign req_err  = (req_size == 2'd3)
                 || ((req_size == SZ_HALF) && req_addr[0])
                 || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                 || !in_range;

`ifdef DMEM_PATTERN_EN
  assign req_pat = in_range && (offset < 32'(PATTERN_WORDS * 4));
`else
  assign req_pat = 1'b0;
`endif

  assign accept = (state_q == IDLE) && req_valid;

  // Store path: commit at the accept edge; pattern-region stores are dropped.
  logic [3:0]  arr_we;
  logic [31:0] arr_wdata;

  always_comb begin
    arr_we    = 4'b0000;
    arr_wdata = req_wdata;
    if (accept && req_write && !req_err && !req_pat) begin
      arr_we = strobe_gen(req_addr[1:0], req_size);
    end
    if (req_size == SZ_BYTE) begin
      arr_wdata = {4{req_wdata[7:0]}};
    end else if (req_size == SZ_HALF) begin
      arr_wdata = {2{req_wdata[15:0]}};
    end
  end

  // Read path: the live request addresses the array while idle (latency 1
  // captures at accept); otherwise the registered index is used.
  logic [AW-1:0] rd_idx;
  logic          rd_pat;
  logic [31:0]   arr_rdata;
  logic [31:0]   rd_word;

  assign rd_idx  = (state_q == IDLE) ? req_idx : idx_q;
  assign rd_pat  = (state_q == IDLE) ? req_pat : pat_q;
  assign rd_word = rd_pat ? (32'h1 << rd_idx) : arr_rdata;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (arr_we),
    .waddr_i (req_idx),
    .wdata_i (arr_wdata),
    .raddr_i (rd_idx),
    .rdata_o (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      idx_q   <= '0;
      lane_q  <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      pat_q   <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      pat_q   <= pat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    size_d  = size_q;
    uns_d   = uns_q;
    pat_d   = pat_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d  = req_idx;
          lane_d = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          pat_d  = req_pat;
          if (req_err || req_write) begin
            rdata_d = 32'h0;
            err_d   = req_err;
            state_d = RESP;
          end else if (READ_LATENCY == 1) begin
            rdata_d = load_extract(rd_word, req_addr[1:0], req_size, req_unsigned);
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            // Counter covers the cycles between the WAIT entry and capture.
            cnt_d   = 2'(READ_LATENCY - 2);
            rdata_d = 32'h0;
            err_d   = 1'b0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d = load_extract(rd_word, lane_q, size_q, uns_q);
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl against a byte-level model

module tb_dmem_ctrl;

  localparam int          DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          LAT   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem_m [DEPTH*4];

  always #5 clk = ~clk;

  dmem_ctrl #(
    .DEPTH_WORDS  (DEPTH),
    .BASE_ADDR    (BASE),
    .READ_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  function automatic bit is_pat(input logic [31:0] o);
`ifdef DMEM_PATTERN_EN
    return (o < 32'd128);
`else
    return (o > 32'hFFFF_FFFF);
`endif
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] o);
    logic [31:0] w;
    if (is_pat(o)) begin
      w = 32'h1 << (o / 4);
      return w[8*(o%4) +: 8];
    end
    return mem_m[o];
  endfunction

  // Reference: byte-addressed memory, applies stores, returns expected response.
  task automatic model(input logic w, input logic [31:0] a, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
    logic [31:0] off;
    logic [31:0] v;
    int n;
    off = a - BASE;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e = (sz == 2'd3) || ((a & 32'(n - 1)) != 0) || (off >= 32'(DEPTH * 4));
    d = 32'h0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++)
          if (!is_pat(off + 32'(i))) mem_m[off + 32'(i)] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(byte_at(off + 32'(i))) << (8 * i));
        if (!u && n < 4 && v[8*n-1]) v = v - (32'd1 << (8 * n));
        d = v;
      end
    end
  endtask

  task automatic do_txn(input string tag, input logic w, input logic [31:0] a,
                        input logic [1:0] sz, input logic u, input logic [31:0] wd,
                        output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    logic        exp_e;
    int          exp_lat;
    int          cyc;
    model(w, a, sz, u, wd, exp_d, exp_e);
    exp_lat = (w || exp_e) ? 1 : LAT;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
    req_unsigned = u; req_wdata = wd;
    cyc = 0;
    while (!req_ready && cyc < 100) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
    cyc = 1;
    while (!resp_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    got_d = resp_rdata;
    got_e = resp_err;
    checks++;
    if (cyc != exp_lat) begin
      errors++;
      $display("FAIL %s latency addr=%h: got %0d cycles, expected %0d", tag, a, cyc, exp_lat);
    end
    checks++;
    if (resp_rdata !== exp_d) begin
      errors++;
      $display("FAIL %s rdata addr=%h sz=%0d w=%0d: got %h, expected %h", tag, a, sz, w, resp_rdata, exp_d);
    end
    checks++;
    if (resp_err !== exp_e) begin
      errors++;
      $display("FAIL %s err addr=%h sz=%0d: got %0d, expected %0d", tag, a, sz, resp_err, exp_e);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    int bad;
    req_valid = 1'b1; req_write = 1'b1; req_addr = BASE + 32'h300;
    req_size = 2'd2; req_wdata = 32'hCAFE_F00D;
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_hold: got %0d bad cycles, expected 0", bad);
    end
    checks++;
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdata=%h err=%0d, expected 0/0", resp_rdata, resp_err);
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%0d valid=%0d, expected 1/0", req_ready, resp_valid);
    end
  endtask

  task automatic test_fill;
    logic [31:0] d; logic e;
    for (int i = 0; i < DEPTH; i++)
      do_txn("fill", 1'b1, BASE + 32'(4 * i), 2'd2, 1'b0, $urandom, d, e);
  endtask

  task automatic test_directed;
    logic [31:0] d; logic e;
    do_txn("st_word", 1'b1, BASE + 32'h100, 2'd2, 1'b0, 32'hDEAD_BEEF, d, e);
    do_txn("ld_word", 1'b0, BASE + 32'h100, 2'd2, 1'b0, 32'h0, d, e);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL const_word: got %h, expected DEADBEEF", d); end
    do_txn("st_byte", 1'b1, BASE + 32'h103, 2'd0, 1'b0, 32'h0000_0080, d, e);
    do_txn("ld_sbyte", 1'b0, BASE + 32'h103, 2'd0, 1'b0, 32'h0, d, e);
    checks++;
    if (d !== 32'hFFFF_FF80) begin errors++; $display("FAIL const_sbyte: got %h, expected FFFFFF80", d); end
    do_txn("ld_ubyte", 1'b0, BASE + 32'h103, 2'd0, 1'b1, 32'h0, d, e);
    checks++;
    if (d !== 32'h0000_0080) begin errors++; $display("FAIL const_ubyte: got %h, expected 00000080", d); end
    do_txn("ld_word2", 1'b0, BASE + 32'h100, 2'd2, 1'b0, 32'h0, d, e);
    checks++;
    if (d !== 32'h80AD_BEEF) begin errors++; $display("FAIL const_merge: got %h, expected 80ADBEEF", d); end
    do_txn("err_half", 1'b0, BASE + 32'h101, 2'd1, 1'b0, 32'h0, d, e);
    do_txn("err_wst", 1'b1, BASE + 32'h102, 2'd2, 1'b0, 32'h1111_2222, d, e);
    do_txn("err_size", 1'b1, BASE + 32'h100, 2'd3, 1'b0, 32'h3333_4444, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL const_err_size: got err=%0d rdata=%h, expected 1/0", e, d); end
    do_txn("err_range", 1'b0, BASE + 32'(DEPTH * 4), 2'd2, 1'b0, 32'h0, d, e);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL const_err_range: got err=%0d rdata=%h, expected 1/0", e, d); end
    do_txn("err_below", 1'b0, BASE - 32'h4, 2'd2, 1'b0, 32'h0, d, e);
    do_txn("ld_after_err", 1'b0, BASE + 32'h100, 2'd2, 1'b0, 32'h0, d, e);
    checks++;
    if (d !== 32'h80AD_BEEF) begin errors++; $display("FAIL const_unchanged: got %h, expected 80ADBEEF", d); end
  endtask

  task automatic test_stall;
    int cyc; int bad;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = BASE + 32'h100;
    req_size = 2'd2; req_unsigned = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom;
    cyc = 0;
    while (!resp_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h80AD_BEEF || resp_err !== 1'b0 || req_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles, expected 0", bad); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got valid=%0d ready=%0d, expected 0/1", resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_wait;
    int bad; logic [31:0] d; logic e;
    req_valid = 1'b1; req_write = 1'b0; req_addr = BASE + 32'h100; req_size = 2'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_now: got valid=%0d ready=%0d, expected 0/1", resp_valid, req_ready);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin @(posedge clk); #1; if (resp_valid !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_wait_drop: got %0d response cycles, expected 0", bad); end
    do_txn("after_rst", 1'b0, BASE + 32'h100, 2'd2, 1'b0, 32'h0, d, e);
    checks++;
    if (d !== 32'h80AD_BEEF) begin errors++; $display("FAIL rst_keep: got %h, expected 80ADBEEF", d); end
  endtask

  task automatic test_pattern;
    logic [31:0] d; logic e;
    do_txn("pat_ld", 1'b0, BASE + 32'h14, 2'd2, 1'b0, 32'h0, d, e);
`ifdef DMEM_PATTERN_EN
    checks++;
    if (d !== 32'h0000_0020) begin errors++; $display("FAIL pat_ld_const: got %h, expected 00000020", d); end
`endif
    do_txn("pat_st", 1'b1, BASE + 32'h14, 2'd2, 1'b0, 32'h0000_1234, d, e);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL pat_st_err: got %0d, expected 0", e); end
    do_txn("pat_ld2", 1'b0, BASE + 32'h14, 2'd2, 1'b0, 32'h0, d, e);
    checks++;
`ifdef DMEM_PATTERN_EN
    if (d !== 32'h0000_0020) begin errors++; $display("FAIL pat_ld2_const: got %h, expected 00000020", d); end
`else
    if (d !== 32'h0000_1234) begin errors++; $display("FAIL pat_ld2_const: got %h, expected 00001234", d); end
`endif
  endtask

  task automatic b2b_run(input string tag, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input int period, input int first);
    logic [31:0] d; logic e;
    int seen; int expn; int bad; int cyc;
    model(w, a, 2'd2, 1'b0, wd, d, e);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = wd;
    seen = 0; expn = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (resp_valid) begin
        seen++;
        if (resp_rdata !== d || resp_err !== 1'b0) bad++;
      end
      if (k % period == first) expn++;
    end
    req_valid = 1'b0;
    cyc = 0;
    while ((!req_ready || resp_valid) && cyc < 20) begin @(posedge clk); #1; cyc++; end
    checks++;
    if (seen != expn) begin errors++; $display("FAIL %s count: got %0d responses, expected %0d", tag, seen, expn); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s data: got %0d bad responses, expected 0", tag, bad); end
  endtask

  task automatic test_back_to_back;
    b2b_run("b2b_load", 1'b0, BASE + 32'h100, 32'h0, LAT + 1, LAT - 1);
    b2b_run("b2b_store", 1'b1, BASE + 32'h200, 32'hA5A5_0F0F, 2, 0);
  endtask

  task automatic test_random;
    logic [31:0] d; logic e; logic [31:0] a; logic [1:0] sz; int r;
    for (int t = 0; t < 300; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = $urandom;
      else if (r == 1) a = BASE + 32'($urandom_range(0, 127));
      else a = BASE + 32'($urandom_range(0, DEPTH * 4 + 3));
      sz = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      do_txn("random", 1'($urandom), a, sz, 1'($urandom), $urandom, d, e);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_directed();
    test_stall();
    test_reset_wait();
    test_pattern();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
